// File: rtl/decoder_pkg.sv
// decoder_pkg: shared types and constants for the token-to-text decoder.
// Holds the FSM state enum and the end-of-stream token value.
package decoder_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 4;
  localparam int unsigned DEF_DATA_WIDTH = 8;

  localparam logic [DEF_DATA_WIDTH-1:0] TOK_END = '1;

  typedef enum logic [3:0] {
    IDLE,
    T_FETCH,
    T_EVAL,
    SEEK,
    SEEK_EV,
    COPY_RD,
    COPY_WR,
    FIN,
    DONE,
    BUILD,
    BUILD_EV
  } decoder_state;

endpackage

// File: rtl/decoder_if.sv
// decoder_if: memory bus between the decoder and its three srams.
// master drives token/vocab read addresses and output write port.
interface decoder_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] tok_addr;
  logic [DATA_WIDTH-1:0] tok_dout;
  logic [ADDR_WIDTH-1:0] voc_addr;
  logic [DATA_WIDTH-1:0] voc_dout;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic [DATA_WIDTH-1:0] out_din;
  logic                  out_we;

  modport master (
    output tok_addr,
    input  tok_dout,
    output voc_addr,
    input  voc_dout,
    output out_addr,
    output out_din,
    output out_we
  );

  modport slave (
    input  tok_addr,
    output tok_dout,
    input  voc_addr,
    output voc_dout,
    input  out_addr,
    input  out_din,
    input  out_we
  );
endinterface

// File: rtl/decoder_vocab_index.sv
// vocab_index: word start-address table filled during the BUILD pass.
// Ports: clr restarts, en/addr/data feed one vocab char, idx -> start, nwords.
module vocab_index #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [ADDR_WIDTH-1:0] idx,
  output logic [ADDR_WIDTH-1:0] start,
  output logic [ADDR_WIDTH-1:0] nwords
);

  logic [ADDR_WIDTH-1:0] tbl [2**ADDR_WIDTH];
  logic at_start;
  logic stopped;
  logic rec;

  // A nonzero char right after a terminator (or at 0) opens a word;
  // a zero there is the empty word that ends the vocab.
  assign rec = en && !clr && !stopped && at_start
            && (data != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nwords   <= '0;
      at_start <= 1'b1;
      stopped  <= 1'b0;
    end else if (clr) begin
      nwords   <= '0;
      at_start <= 1'b1;
      stopped  <= 1'b0;
    end else if (en && !stopped) begin
      if (at_start) begin
        if (data == '0) begin
          stopped <= 1'b1;
        end else begin
          nwords   <= nwords + 1'b1;
          at_start <= 1'b0;
        end
      end else if (data == '0) begin
        at_start <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rec) tbl[nwords] <= addr;
  end

  assign start = tbl[idx];

endmodule

// File: rtl/decoder.sv
// decoder: expands vocab-index tokens into null-terminated words.
// Ports: clk, rst, cs start, done/err status, mem bus. Option: DECODER_INDEX_CACHE_EN.
module decoder
  import decoder_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic cs,
  output logic done,
  output logic err,
  decoder_if.master mem
);

  localparam logic [ADDR_WIDTH-1:0] AMAX = '1;

  decoder_state state;
  logic [ADDR_WIDTH-1:0] tp;
  logic [ADDR_WIDTH-1:0] va;
  logic [ADDR_WIDTH-1:0] op;
  logic tok_end;
  logic wr_cpy;

`ifdef DECODER_INDEX_CACHE_EN
  logic [ADDR_WIDTH-1:0] start_addr;
  logic [ADDR_WIDTH-1:0] nwords;
  logic                  bad_k;

  vocab_index #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_index (
    .clk   (clk),
    .rst   (rst),
    .clr   ((state == IDLE || state == DONE) && cs),
    .en    (state == BUILD_EV),
    .addr  (va),
    .data  (mem.voc_dout),
    .idx   (mem.tok_dout[ADDR_WIDTH-1:0]),
    .start (start_addr),
    .nwords(nwords)
  );

  assign bad_k = mem.tok_dout >= DATA_WIDTH'(nwords);
`else
  logic [DATA_WIDTH-1:0] k;
  logic [DATA_WIDTH-1:0] cnt;
  logic                  prevz;
`endif

  assign tok_end = &mem.tok_dout;

  // The write port is purely combinational so reset kills it at once.
  assign wr_cpy       = (state == COPY_WR) && (op != AMAX);
  assign mem.tok_addr = tp;
  assign mem.voc_addr = va;
  assign mem.out_addr = op;
  assign mem.out_we   = wr_cpy || (state == FIN);
  assign mem.out_din  = wr_cpy ? mem.voc_dout : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      tp    <= '0;
      va    <= '0;
      op    <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
`ifndef DECODER_INDEX_CACHE_EN
      k     <= '0;
      cnt   <= '0;
      prevz <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (cs) begin
            tp   <= '0;
            op   <= '0;
            va   <= '0;
            err  <= 1'b0;
            done <= 1'b0;
`ifdef DECODER_INDEX_CACHE_EN
            state <= BUILD;
`else
            state <= T_FETCH;
`endif
          end
        end
`ifdef DECODER_INDEX_CACHE_EN
        BUILD: state <= BUILD_EV;
        BUILD_EV: begin
          if (va == AMAX) begin
            va    <= '0;
            state <= T_FETCH;
          end else begin
            va    <= va + 1'b1;
            state <= BUILD;
          end
        end
`endif
        T_FETCH: state <= T_EVAL;
        T_EVAL: begin
          va <= '0;
          if (tok_end || tp == AMAX) begin
            state <= FIN;
          end else if (mem.tok_dout == '0) begin
            state <= COPY_RD;
`ifdef DECODER_INDEX_CACHE_EN
          end else if (bad_k) begin
            err   <= 1'b1;
            tp    <= tp + 1'b1;
            state <= T_FETCH;
          end else begin
            va    <= start_addr;
            state <= COPY_RD;
          end
        end
`else
          end else begin
            k     <= mem.tok_dout;
            cnt   <= '0;
            prevz <= 1'b0;
            state <= SEEK;
          end
        end
        SEEK: state <= SEEK_EV;
        SEEK_EV: begin
          prevz <= (mem.voc_dout == '0);
          if (mem.voc_dout == '0) begin
            // Terminator at AMAX leaves no room for a next word.
            if (prevz || va == '0 || va == AMAX) begin
              err   <= 1'b1;
              tp    <= tp + 1'b1;
              state <= T_FETCH;
            end else if (cnt + DATA_WIDTH'(1) == k) begin
              va    <= va + 1'b1;
              state <= COPY_RD;
            end else begin
              cnt   <= cnt + DATA_WIDTH'(1);
              va    <= va + 1'b1;
              state <= SEEK;
            end
          end else if (va == AMAX) begin
            err   <= 1'b1;
            tp    <= tp + 1'b1;
            state <= T_FETCH;
          end else begin
            va    <= va + 1'b1;
            state <= SEEK;
          end
        end
`endif
        COPY_RD: state <= COPY_WR;
        COPY_WR: begin
          if (op == AMAX) begin
            // Last cell is reserved for the closing zero.
            err   <= 1'b1;
            state <= FIN;
          end else begin
            op <= op + 1'b1;
            if (mem.voc_dout == '0) begin
              tp    <= tp + 1'b1;
              state <= T_FETCH;
            end else begin
              va    <= va + 1'b1;
              state <= COPY_RD;
            end
          end
        end
        FIN: begin
          done  <= 1'b1;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_decoder.sv
// tb_decoder: directed scoreboard bench for decoder with sram models.
// Expected writes are queued per test; a negedge monitor pops and compares.
module tb_decoder;
  import decoder_pkg::*;

  localparam int AW = 4;
  localparam int DW = 8;
`ifdef DECODER_INDEX_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cs  = 1'b0;
  logic done;
  logic err;

  decoder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  decoder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .cs  (cs),
    .done(done),
    .err (err),
    .mem (bus)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] tok_mem [16];
  logic [DW-1:0] voc_mem [16];
  logic [DW-1:0] out_mem [16];

  always @(posedge clk) begin
    bus.tok_dout <= tok_mem[bus.tok_addr];
    bus.voc_dout <= voc_mem[bus.voc_addr];
    if (bus.out_we) out_mem[bus.out_addr] <= bus.out_din;
  end

  wr_t expq[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (!rst && bus.out_we) begin
      if (expq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got %0h@%0h expected none",
                 bus.out_din, bus.out_addr);
      end else begin
        e = expq.pop_front();
        check("wr_addr", 32'(bus.out_addr), 32'(e.a));
        check("wr_data", 32'(bus.out_din), 32'(e.d));
      end
    end
  end

  task automatic push(int a, int d);
    wr_t e;
    e.a = AW'(a);
    e.d = DW'(d);
    expq.push_back(e);
  endtask

  task automatic load_tok(input logic [DW-1:0] t[$]);
    for (int i = 0; i < 16; i++) tok_mem[i] = TOK_END;
    foreach (t[i]) tok_mem[i] = t[i];
  endtask

  task automatic pulse_cs();
    @(negedge clk);
    cs = 1'b1;
    @(posedge clk);
    #1 cs = 1'b0;
  endtask

  task automatic run(string nm, int cyc_nc, int cyc_c, logic exp_err);
    int n;
    pulse_cs();
    n = 0;
    while (n < 300) begin
      @(posedge clk);
      #1 n++;
      if (done) break;
    end
    check({nm, "_cycles"}, 32'(n), 32'(CACHE ? cyc_c : cyc_nc));
    check({nm, "_done"}, 32'(done), 32'd1);
    check({nm, "_err"}, 32'(exp_err), 32'(err));
    check({nm, "_pending"}, 32'(expq.size()), 32'd0);
    expq.delete();
  endtask

  task automatic push_case1();
    push(0, 8'h63); push(1, 8'h61); push(2, 8'h74); push(3, 0);
    push(4, 8'h68); push(5, 8'h69); push(6, 0); push(7, 0);
  endtask

  initial begin
    logic [DW-1:0] voc [11];
    logic [DW-1:0] t1[$];
    logic [DW-1:0] t2[$];
    logic [DW-1:0] t3[$];
    logic [DW-1:0] t4[$];
    voc = '{8'h68, 8'h69, 8'h00, 8'h63, 8'h61, 8'h74,
            8'h00, 8'h67, 8'h6F, 8'h00, 8'h00};
    for (int i = 0; i < 16; i++) begin
      voc_mem[i] = '0;
      out_mem[i] = 8'hEE;
    end
    for (int i = 0; i < 11; i++) voc_mem[i] = voc[i];
    t1 = '{8'h01, 8'h00, 8'hFF};
    t2 = '{8'h02, 8'h05, 8'hFF};
    t3 = '{8'hFF};
    t4 = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'hFF};
    load_tok(t3);

    repeat (2) @(posedge clk);
    #1;
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_we", 32'(bus.out_we), 32'd0);
    check("rst_tok_addr", 32'(bus.tok_addr), 32'd0);
    check("rst_voc_addr", 32'(bus.voc_addr), 32'd0);
    check("rst_out_addr", 32'(bus.out_addr), 32'd0);
    check("rst_out_din", 32'(bus.out_din), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    load_tok(t1);
    push_case1();
    run("case1", 27, 53, 1'b0);
    check("case1_out7", 32'(out_mem[7]), 32'd0);

    load_tok(t2);
    push(0, 8'h67); push(1, 8'h6F); push(2, 0); push(3, 0);
    run("case2", 49, 45, 1'b1);

    load_tok(t3);
    push(0, 0);
    run("case3", 3, 35, 1'b0);

    load_tok(t4);
    for (int w = 0; w < 4; w++) begin
      push(4*w, 8'h63);
      push(4*w+1, 8'h61);
      push(4*w+2, 8'h74);
      if (w < 3) push(4*w+3, 0);
    end
    push(15, 0);
    run("case4", 65, 73, 1'b1);
    check("case4_out15", 32'(out_mem[15]), 32'd0);

    load_tok(t1);
    push_case1();
    pulse_cs();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.out_we) break;
    end
    check("abort_saw_write", 32'(bus.out_we), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("abort_we", 32'(bus.out_we), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_state", 32'(dut.state), 32'(IDLE));
    expq.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    push_case1();
    run("case5", 27, 53, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/decoder.md
# decoder

Token-to-text expander; the inverse of the word encoder. Starting on a `cs` pulse, it walks a token RAM of vocabulary indices. For each index it locates the matching null-terminated word in the vocab RAM and copies it, terminator included, into an output RAM. All three RAMs are external `sram` instances with one-cycle synchronous read.

## Interface
- `ADDR_WIDTH`, 4, address width of all three RAMs; max address `AMAX = 2^ADDR_WIDTH-1`
- `DATA_WIDTH`, 8, character/token width
- `clk` in 1, single clock, rising edge
- `rst` in 1, asynchronous, active-high reset
- `cs` in 1, start request, sampled in IDLE and DONE
- `done` out 1, registered; high while in DONE
- `err` out 1, registered, sticky until next start: invalid token or output overflow
- `tok_addr` out ADDR_WIDTH, token RAM read address
- `tok_dout` in DATA_WIDTH, token RAM data, valid the cycle after address
- `voc_addr` out ADDR_WIDTH, vocab RAM read address
- `voc_dout` in DATA_WIDTH, vocab RAM data, one-cycle latency
- `out_addr` out ADDR_WIDTH, output RAM address
- `out_din` out DATA_WIDTH, output RAM write data
- `out_we` out 1, output RAM write enable

## Operation
- Vocab format: words stored back to back, each terminated by 0. An empty word (0 at address 0, or two consecutive 0s) marks the end of the vocab. Token k selects the k-th word, 0-based.
- Token stream ends at `TOK_END` (all ones). The token at address AMAX is always treated as `TOK_END`.
- Output stream: each selected word followed by a 0, then one extra 0. The stream therefore ends with a double zero, matching the encoder's end-of-stream convention.
- Registers: `tp` (token pointer), `va` (vocab pointer), `op` (output pointer), `k` (target index), `cnt` (words skipped), `prevz` (previous character was 0).
- State transitions:
  - IDLE: if `cs`, clear `tp`, `op`, `err`, `done` -> T_FETCH.
  - T_FETCH: `tok_addr=tp` -> T_EVAL.
  - T_EVAL: on `TOK_END` or `tp==AMAX` -> FIN. On k==0, `va=0` -> COPY_RD. Otherwise `va=0`, `cnt=0` -> SEEK.
  - SEEK: `voc_addr=va` -> SEEK_EV.
  - SEEK_EV, `voc_dout==0`:
    - if `prevz` or `va==0`: empty word reached, `err=1`, `tp++` -> T_FETCH.
    - else if `cnt+1==k`: `va++` -> COPY_RD.
    - else: `cnt++`, `va++` -> SEEK.
  - SEEK_EV, `voc_dout!=0`: if `va==AMAX`, `err=1`, `tp++` -> T_FETCH; else `va++` -> SEEK.
  - COPY_RD: `voc_addr=va` -> COPY_WR.
  - COPY_WR:
    - if `op==AMAX`: overflow, `err=1`, no write -> FIN.
    - else: `out_we=1`, `out_addr=op`, `out_din=voc_dout`, `op++`. If `voc_dout==0`, `tp++` -> T_FETCH; else `va++` -> COPY_RD.
  - FIN: write 0 at `op`, `op` unchanged -> DONE.
  - DONE: `done=1`. If `cs`, restart exactly as from IDLE.
- Pointer arithmetic is modulo 2^ADDR_WIDTH. Wrap never happens: the AMAX checks above take effect first.

## Timing
- Reset: state IDLE; all pointers 0; `done=0`, `err=0`, `out_we=0`; all addresses 0, `out_din=0`. Reset mid-run aborts immediately and `out_we` drops asynchronously.
- Memory address, data and `we` outputs are combinational from state and pointer registers.
- Cycle budget from `cs` sample to DONE entry:
  - 2 per token
  - +2 per vocab character scanned (scan only, not the cached lookup)
  - +2 per copied character, terminator included
  - +1 for FIN
- `cs` held high in DONE restarts every cycle after finishing; software pulses `cs` for one cycle.

## Configuration
- `DECODER_INDEX_CACHE_EN` defined:
  - After a start, a BUILD pass reads vocab 0..AMAX once, 2 cycles per address.
  - It records each word's start address in a 2^ADDR_WIDTH-entry table and counts `nwords`, stopping at the empty word.
  - T_EVAL then loads `va=table[k]` directly; `k>=nwords` sets `err`.
  - The table is rebuilt on every start.
- Undefined: linear SEEK scan per token.
- Output RAM contents and `err` are identical either way; only latency differs.

## Structure
- `decoder_pkg`: `decoder_state` enum (IDLE, T_FETCH, T_EVAL, SEEK, SEEK_EV, COPY_RD, COPY_WR, FIN, DONE, plus BUILD and BUILD_EV), and `TOK_END`.
- Sub-module `vocab_index`: start-address table and `nwords` counter, instantiated only under `DECODER_INDEX_CACHE_EN`.

## Test plan
- Vocab: 68 69 00 63 61 74 00 67 6F 00 00 ("hi", "cat", "go").
- Tokens 01 00 FF -> output[0..7] = 63 61 74 00 68 69 00 00; `done=1`, `err=0`; no-cache run takes 27 cycles from `cs` to DONE.
- Tokens 02 05 FF -> output 67 6F 00 00; `err=1`, token 5 skipped, `done=1`.
- Tokens FF -> output[0]=00; `done=1` after 3 cycles.
- Tokens 01 ×6 then FF -> writes stop at `op=15`, which receives the final 00; `err=1`.
- `rst` asserted mid-COPY_WR -> `out_we=0` at once, `done=0`, state IDLE; a following `cs` reproduces case 1 exactly.
- Rerun case 1 with `DECODER_INDEX_CACHE_EN` -> identical output and `err`; cycle count differs as specified.
